frame_source_sel: RTL and testbench
===================================

Name: frame_source_sel

Overview:
- Parametrised successor to the display path's frame-input multiplexer.
- Selects one of NUM_BUF line-buffer streams, or a constant blank stream, and drives the frame-input port.
- Adds a valid/ready handshake on every source and on the output, plus a 1-deep registered output stage.
- Source switches take effect only at a frame boundary, so a frame is never split across sources.
- Illegal (non-one-hot) selection requests are flagged and ignored.

Parameters:
- DATA_W, 8, pixel width in bits.
- NUM_BUF, 2, number of buffer sources (>=1).
- BLANK_VAL, 0, DATA_W-bit value emitted by the blank source.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- SelBuf  input  NUM_BUF  requested buffer source, one-hot.
- SelBlank  input  1  requests the blank source.
- FrameSync  input  1  single-cycle frame-boundary pulse from the timing generator.
- BufData  input  NUM_BUF*DATA_W  source data; source k occupies bits [k*DATA_W +: DATA_W].
- BufValid  input  NUM_BUF  per-source data valid.
- BufReady  output  NUM_BUF  per-source ready.
- FrameIn  output  DATA_W  selected pixel.
- FrameValid  output  1  FrameIn holds a beat.
- FrameReady  input  1  downstream accepts the beat.
- ActiveSrc  output  $clog2(NUM_BUF+1)  committed source: 0..NUM_BUF-1 are buffers, NUM_BUF is blank.
- SelErr  output  1  the current request is not one-hot.

Behaviour:
- Reset (async assert, sync release) sets:
  - FrameIn=0, FrameValid=0, BufReady=0, SelErr=0;
  - ActiveSrc=NUM_BUF (blank), pending=NUM_BUF, state=RUN.
  - Reset asserted mid-frame or mid-drain aborts immediately; the in-flight beat is discarded.
- Request decode is combinational over {SelBuf, SelBlank}:
  - The request is valid when exactly one bit is set.
  - A valid request loads the pending register on the next edge.
  - An invalid request (0 bits or >=2 bits) leaves pending unchanged. SelErr is registered and goes high 1 cycle after the invalid request appears, staying high until the request is legal.
- Output stage:
  - slot_free = !FrameValid || FrameReady.
  - In RUN, BufReady[k] = slot_free && (ActiveSrc==k); all other ready bits are 0.
  - A buffer beat transfers when BufValid[k] && BufReady[k]. The blank source is always valid and produces BLANK_VAL whenever slot_free.
  - On a transfer, FrameIn/FrameValid load on the next edge, giving 1-cycle latency.
  - FrameValid && !FrameReady holds FrameIn stable, and no new beat is accepted.
  - When the active buffer has no valid beat and slot_free holds, FrameValid drops to 0.
- State machine:
  - RUN: normal transfer. On FrameSync with pending != ActiveSrc, go to DRAIN. If pending == ActiveSrc, stay in RUN with no bubble.
  - DRAIN: all BufReady=0 and the blank source is suppressed. When !FrameValid || FrameReady, FrameValid clears, ActiveSrc <= pending (the value at that edge), and the block goes to RUN. Transfers from the new source begin the following cycle.
  - FrameSync during DRAIN is ignored. A request change during DRAIN updates pending and is used at commit.
- BufReady is a combinational function of state, ActiveSrc, FrameValid and FrameReady. It has no combinational dependency on BufValid.

Decomposition:
- Shared display package holds:
  - state encoding (RUN, DRAIN);
  - source-index width function clog2(NUM_BUF+1);
  - the BLANK_IDX=NUM_BUF convention.
- One sub-module, sel_onehot_decode: parameter NUM_BUF; inputs SelBuf and SelBlank; outputs req_ok and req_idx. It is pure combinational and is reused by the other display muxes.
- Handshake, state machine and output register live in the top module.

Test Plan:
- Reset default: assert Reset mid-stream with FrameValid=1 -> FrameValid=0, FrameIn=0x00, ActiveSrc=2 (NUM_BUF=2), BufReady=2'b00 immediately. After release with FrameReady=1, FrameIn=0x00 with FrameValid=1 every cycle.
- Switch at boundary: SelBuf=01, stream 0x11,0x12,... on buf0, then FrameSync -> one DRAIN bubble, ActiveSrc=0, first output 0x11 two cycles after the sync. Changing SelBuf to 10 mid-frame keeps ActiveSrc=0 until the next FrameSync.
- Backpressure: FrameReady=0 for 5 cycles while FrameIn=0x42 -> FrameIn holds 0x42, BufReady[0]=0, and no beat is lost or duplicated. Verify the sequence 0x42,0x43,0x44 after release.
- Illegal request: SelBuf=11 with SelBlank=0, then SelBuf=00 with SelBlank=0 -> SelErr=1 from the cycle after each appears, and FrameSync leaves ActiveSrc unchanged. SelBlank=1 alone clears SelErr and the next FrameSync commits ActiveSrc=2.
- Drain under stall: FrameSync with pending!=active, FrameValid=1 and FrameReady=0 for 3 cycles -> state stays DRAIN, all BufReady=0, and the commit happens on the edge where FrameReady=1.
- Parametrisation: DATA_W=12, NUM_BUF=4, BLANK_VAL=0x800 -> routing of each source k=0..3 is correct, and blank outputs 0x800 with ActiveSrc=4.

Source files
------------

// File: rtl/frame_source_sel_pkg.sv
// Shared display-path definitions: mux state encoding and source-index helpers.
package frame_source_sel_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } selState_t;

    // Width of a source index covering NUM_BUF buffers plus the blank source.
    function automatic int unsigned srcIdxW(input int unsigned numBuf);
        return (numBuf < 1) ? 1 : $clog2(numBuf + 1);
    endfunction

    // The blank source always sits one past the last buffer index.
    function automatic int unsigned blankIdx(input int unsigned numBuf);
        return numBuf;
    endfunction

endpackage

// File: rtl/frame_source_sel_onehot_decode.sv
// One-hot decode of a {buffer, blank} source request into a source index.
module sel_onehot_decode
    import frame_source_sel_pkg::*;
#(
    parameter int unsigned NUM_BUF = 2
) (
    input  logic [NUM_BUF-1:0]                SelBuf,
    input  logic                              SelBlank,
    output logic                              req_ok,
    output logic [srcIdxW(NUM_BUF)-1:0]       req_idx
);

    localparam int unsigned IDX_W = srcIdxW(NUM_BUF);

    // Legal only with exactly one request bit set; index defaults to blank.
    always_comb begin
        req_ok  = ($countones({SelBuf, SelBlank}) == 1);
        req_idx = IDX_W'(blankIdx(NUM_BUF));
        for (int unsigned k = 0; k < NUM_BUF; k++) begin
            if (SelBuf[k]) req_idx = IDX_W'(k);
        end
    end

endmodule

// File: rtl/frame_source_sel.sv
// Frame-input source multiplexer with valid/ready handshake and
// frame-boundary source switching through a drain state.
module frame_source_sel
    import frame_source_sel_pkg::*;
#(
    parameter int unsigned     DATA_W    = 8,
    parameter int unsigned     NUM_BUF   = 2,
    parameter logic [DATA_W-1:0] BLANK_VAL = '0
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic [NUM_BUF-1:0]            SelBuf,
    input  logic                          SelBlank,
    input  logic                          FrameSync,
    input  logic [NUM_BUF*DATA_W-1:0]     BufData,
    input  logic [NUM_BUF-1:0]            BufValid,
    output logic [NUM_BUF-1:0]            BufReady,
    output logic [DATA_W-1:0]             FrameIn,
    output logic                          FrameValid,
    input  logic                          FrameReady,
    output logic [srcIdxW(NUM_BUF)-1:0]   ActiveSrc,
    output logic                          SelErr
);

    localparam int unsigned      IDX_W = srcIdxW(NUM_BUF);
    localparam logic [IDX_W-1:0] BLANK = IDX_W'(blankIdx(NUM_BUF));

    selState_t        state;
    logic [IDX_W-1:0] pending;
    logic             reqOk;
    logic [IDX_W-1:0] reqIdx;
    logic             slotFree;
    logic [DATA_W-1:0] selData;
    logic             selValid;

    sel_onehot_decode #(.NUM_BUF(NUM_BUF)) uDecode (
        .SelBuf  (SelBuf),
        .SelBlank(SelBlank),
        .req_ok  (reqOk),
        .req_idx (reqIdx)
    );

    // Output slot can take a beat when empty or being consumed this cycle.
    always_comb slotFree = !FrameValid || FrameReady;

    // Route the active source; blank is the default and is always valid.
    always_comb begin
        BufReady = '0;
        selData  = BLANK_VAL;
        selValid = 1'b1;
        for (int unsigned k = 0; k < NUM_BUF; k++) begin
            if (ActiveSrc == IDX_W'(k)) begin
                selData     = BufData[k*DATA_W +: DATA_W];
                selValid    = BufValid[k];
                BufReady[k] = (state == RUN) && slotFree;
            end
        end
    end

    // Request capture, output register and RUN/DRAIN switching.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= RUN;
            pending    <= BLANK;
            ActiveSrc  <= BLANK;
            FrameIn    <= '0;
            FrameValid <= 1'b0;
            SelErr     <= 1'b0;
        end else begin
            if (reqOk) pending <= reqIdx;
            SelErr <= !reqOk;
            case (state)
                RUN: begin
                    if (slotFree) begin
                        FrameValid <= selValid;
                        if (selValid) FrameIn <= selData;
                    end
                    if (FrameSync && (pending != ActiveSrc)) state <= DRAIN;
                end
                DRAIN: begin
                    if (slotFree) begin
                        FrameValid <= 1'b0;
                        ActiveSrc  <= pending;
                        state      <= RUN;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_source_sel.sv
// Self-checking bench for frame_source_sel: directed steps plus random traffic
// checked against a cycle-level behavioural model; second instance checks
// a wider parametrisation.
module tb_frame_source_sel;

    localparam int NB = 2;
    localparam int DW = 8;

    logic            Clk = 1'b0;
    logic            Reset;
    logic [NB-1:0]   SelBuf;
    logic            SelBlank;
    logic            FrameSync;
    logic [NB*DW-1:0] BufData;
    logic [NB-1:0]   BufValid;
    logic [NB-1:0]   BufReady;
    logic [DW-1:0]   FrameIn;
    logic            FrameValid;
    logic            FrameReady;
    logic [1:0]      ActiveSrc;
    logic            SelErr;

    logic [3:0]      SelBuf2;
    logic            SelBlank2;
    logic            FrameSync2;
    logic [47:0]     BufData2;
    logic [3:0]      BufValid2;
    logic [3:0]      BufReady2;
    logic [11:0]     FrameIn2;
    logic            FrameValid2;
    logic            FrameReady2;
    logic [2:0]      ActiveSrc2;
    logic            SelErr2;

    int nAsserts = 0;
    int nFail    = 0;

    // Behavioural model state
    bit mValid, mDrain, mErr;
    int mData, mActive, mPending, mAcc;
    int bufCnt;

    frame_source_sel #(.DATA_W(DW), .NUM_BUF(NB), .BLANK_VAL(8'h00)) dut (
        .Clk(Clk), .Reset(Reset), .SelBuf(SelBuf), .SelBlank(SelBlank),
        .FrameSync(FrameSync), .BufData(BufData), .BufValid(BufValid),
        .BufReady(BufReady), .FrameIn(FrameIn), .FrameValid(FrameValid),
        .FrameReady(FrameReady), .ActiveSrc(ActiveSrc), .SelErr(SelErr)
    );

    frame_source_sel #(.DATA_W(12), .NUM_BUF(4), .BLANK_VAL(12'h800)) dut4 (
        .Clk(Clk), .Reset(Reset), .SelBuf(SelBuf2), .SelBlank(SelBlank2),
        .FrameSync(FrameSync2), .BufData(BufData2), .BufValid(BufValid2),
        .BufReady(BufReady2), .FrameIn(FrameIn2), .FrameValid(FrameValid2),
        .FrameReady(FrameReady2), .ActiveSrc(ActiveSrc2), .SelErr(SelErr2)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mValid = 0; mDrain = 0; mErr = 0; mData = 0;
        mActive = NB; mPending = NB; mAcc = -1;
    endtask

    // One clock of the behavioural rules, using pre-edge model state.
    task automatic modelStep();
        int  nb;
        bit  free;
        nb   = $countones({SelBuf, SelBlank});
        free = !mValid || FrameReady;
        mAcc = -1;
        if (!mDrain) begin
            if (free) begin
                if (mActive == NB) begin
                    mValid = 1; mData = 0;
                end else if (BufValid[mActive]) begin
                    mValid = 1; mData = int'(BufData[mActive*DW +: DW]); mAcc = mActive;
                end else begin
                    mValid = 0;
                end
            end
            if (FrameSync && mPending != mActive) mDrain = 1;
        end else if (free) begin
            mValid = 0; mActive = mPending; mDrain = 0;
        end
        if (nb == 1) begin
            mPending = NB;
            for (int k = 0; k < NB; k++) if (SelBuf[k]) mPending = k;
        end
        mErr = (nb != 1);
    endtask

    // Called at posedge+1 with inputs set; checks ready, clocks, checks outputs.
    task automatic tick();
        logic [NB-1:0] expRdy;
        #1;
        expRdy = (!mDrain && (!mValid || FrameReady) && mActive < NB) ? NB'(1 << mActive) : '0;
        check("BufReady", 64'(BufReady), 64'(expRdy));
        @(posedge Clk);
        modelStep();
        #1;
        check("FrameValid", 64'(FrameValid), 64'(mValid));
        if (mValid) check("FrameIn", 64'(FrameIn), 64'(mData));
        check("ActiveSrc", 64'(ActiveSrc), 64'(mActive));
        check("SelErr", 64'(SelErr), 64'(mErr));
    endtask

    // Tick while buf0 presents an incrementing stream.
    task automatic tickStream();
        tick();
        if (mAcc == 0) bufCnt++;
        BufData[7:0] = 8'(bufCnt);
    endtask

    initial begin
        logic [11:0] exp4 [5];
        Reset = 1; SelBuf = '0; SelBlank = 1; FrameSync = 0;
        BufData = '0; BufValid = '0; FrameReady = 1;
        SelBuf2 = '0; SelBlank2 = 1; FrameSync2 = 0; BufValid2 = 4'hF; FrameReady2 = 1;
        for (int k = 0; k < 4; k++) begin
            exp4[k] = 12'(12'h123 + k * 12'h111);
            BufData2[k*12 +: 12] = exp4[k];
        end
        exp4[4] = 12'h800;
        modelReset();
        #1;
        check("rst_FrameValid", 64'(FrameValid), 64'd0);
        check("rst_FrameIn", 64'(FrameIn), 64'd0);
        check("rst_ActiveSrc", 64'(ActiveSrc), 64'd2);
        check("rst_BufReady", 64'(BufReady), 64'd0);
        check("rst_SelErr", 64'(SelErr), 64'd0);
        @(posedge Clk); @(posedge Clk); #1;
        Reset = 0;

        // Blank streaming after reset
        for (int i = 0; i < 3; i++) tick();

        // Switch to buf0 at the frame boundary
        bufCnt = 8'h11; BufData[7:0] = 8'h11; BufValid = 2'b01;
        SelBuf = 2'b01; SelBlank = 0;
        tickStream();
        FrameSync = 1; tickStream(); FrameSync = 0;
        check("drain_bubble", 64'(FrameValid), 64'd1);
        tickStream();
        check("drain_commit_valid", 64'(FrameValid), 64'd0);
        tickStream();
        check("first_beat", 64'(FrameIn), 64'h11);
        check("first_src", 64'(ActiveSrc), 64'd0);
        SelBuf = 2'b10;
        for (int i = 0; i < 4; i++) tickStream();
        check("midframe_hold", 64'(ActiveSrc), 64'd0);
        SelBuf = 2'b01;

        // Backpressure around beat 0x42
        for (int i = 0; i < 200 && !(mValid && mData == 8'h42); i++) tickStream();
        check("reach_42", 64'(FrameIn), 64'h42);
        FrameReady = 0;
        for (int i = 0; i < 5; i++) begin
            tickStream();
            check("bp_hold", 64'(FrameIn), 64'h42);
            check("bp_ready", 64'(BufReady), 64'd0);
        end
        FrameReady = 1;
        tickStream(); check("bp_next1", 64'(FrameIn), 64'h43);
        tickStream(); check("bp_next2", 64'(FrameIn), 64'h44);

        // Illegal requests
        SelBuf = 2'b11; tickStream();
        check("err_11", 64'(SelErr), 64'd1);
        FrameSync = 1; tickStream(); FrameSync = 0;
        tickStream();
        check("err_sync_src", 64'(ActiveSrc), 64'd0);
        SelBuf = 2'b00; tickStream();
        check("err_00", 64'(SelErr), 64'd1);
        FrameSync = 1; tickStream(); FrameSync = 0;
        tickStream();
        check("err00_sync_src", 64'(ActiveSrc), 64'd0);
        SelBlank = 1; tickStream();
        check("err_clear", 64'(SelErr), 64'd0);
        FrameSync = 1; tickStream(); FrameSync = 0;
        tickStream();
        check("blank_commit", 64'(ActiveSrc), 64'd2);

        // Drain while the output is stalled
        SelBuf = 2'b01; SelBlank = 0; tickStream();
        FrameReady = 0; FrameSync = 1; tickStream(); FrameSync = 0;
        for (int i = 0; i < 3; i++) begin
            tickStream();
            check("stall_src", 64'(ActiveSrc), 64'd2);
            check("stall_ready", 64'(BufReady), 64'd0);
        end
        FrameReady = 1; tickStream();
        check("stall_commit", 64'(ActiveSrc), 64'd0);

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(7) == 0) begin
                SelBuf = 2'($urandom); SelBlank = 1'($urandom);
            end
            FrameSync  = ($urandom_range(15) == 0);
            BufValid   = 2'($urandom);
            BufData    = 16'($urandom);
            FrameReady = ($urandom_range(3) != 0);
            tick();
        end
        FrameSync = 0;

        // Wider instance: route each buffer then blank
        for (int k = 0; k < 5; k++) begin
            SelBuf2   = (k < 4) ? 4'(1 << k) : 4'b0000;
            SelBlank2 = (k == 4);
            tick();
            FrameSync2 = 1; tick(); FrameSync2 = 0;
            for (int i = 0; i < 3; i++) tick();
            check("p4_src", 64'(ActiveSrc2), 64'(k));
            check("p4_valid", 64'(FrameValid2), 64'd1);
            check("p4_data", 64'(FrameIn2), 64'(exp4[k]));
        end

        // Reset asserted mid-stream with a beat in flight
        SelBuf = 2'b00; SelBlank = 1; FrameReady = 1; BufValid = 2'b11;
        FrameSync = 1; tick(); FrameSync = 0;
        for (int i = 0; i < 10 && !(mActive == NB && mValid); i++) tick();
        tick();
        check("pre_rst_valid", 64'(FrameValid), 64'd1);
        #2; Reset = 1; #1;
        modelReset();
        check("mid_rst_FrameValid", 64'(FrameValid), 64'd0);
        check("mid_rst_FrameIn", 64'(FrameIn), 64'd0);
        check("mid_rst_ActiveSrc", 64'(ActiveSrc), 64'd2);
        check("mid_rst_BufReady", 64'(BufReady), 64'd0);
        @(posedge Clk); #1; Reset = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_blank", 64'({FrameValid, FrameIn}), 64'h100);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
